// File: rtl/decoder_mul_rr_arbiter_if.sv
// decoder_mul_rr_arbiter_if: requester/multiplier/response bus; slave = arbiter side, master = environment side
interface decoder_mul_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_WIDTH = 2,
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 10,
  parameter int DOUT_WIDTH = 26
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
  logic signed [DIN0_WIDTH-1:0] mul_din0;
  logic signed [DIN1_WIDTH-1:0] mul_din1;
  logic signed [DOUT_WIDTH-1:0] mul_dout;
  logic rsp_valid;
  logic rsp_ready;
  logic signed [DOUT_WIDTH-1:0] rsp_dout;
  logic [ID_WIDTH-1:0] rsp_id;
  logic busy;
  modport slave (
    input req_valid, req_din0, req_din1, mul_dout, rsp_ready,
    output req_ready, mul_din0, mul_din1, rsp_valid, rsp_dout, rsp_id, busy
  );
  modport master (
    output req_valid, req_din0, req_din1, mul_dout, rsp_ready,
    input req_ready, mul_din0, mul_din1, rsp_valid, rsp_dout, rsp_id, busy
  );
endinterface

// File: rtl/decoder_mul_rr_arbiter.sv
// decoder_mul_rr_arbiter: round-robin share of an external signed multiplier; ap_clk/ap_rst plus bus (requests in, mul_din/mul_dout, tagged rsp out, busy)
module decoder_mul_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_WIDTH = 2,
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 10,
  parameter int DOUT_WIDTH = 26
) (
  input logic ap_clk,
  input logic ap_rst,
  decoder_mul_rr_arbiter_if.slave bus
);
  logic s1_v;
  logic signed [DIN0_WIDTH-1:0] a;
  logic signed [DIN1_WIDTH-1:0] b;
  logic [ID_WIDTH-1:0] s1_id, ptr, gnt_id;
  logic gnt, s1_adv, s2_adv;
  assign s2_adv = !bus.rsp_valid || bus.rsp_ready;
  assign s1_adv = !s1_v || s2_adv;
  always_comb begin
    gnt = 1'b0;
    gnt_id = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        gnt = s1_adv && !ap_rst;
        gnt_id = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
  assign bus.req_ready = gnt ? NUM_REQ'(1) << gnt_id : '0;
  assign bus.mul_din0 = s1_v ? a : '0;
  assign bus.mul_din1 = s1_v ? b : '0;
  assign bus.busy = s1_v || bus.rsp_valid;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_v <= 1'b0;
      a <= '0;
      b <= '0;
      s1_id <= '0;
      ptr <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_dout <= '0;
      bus.rsp_id <= '0;
    end else begin
      if (s1_adv) s1_v <= gnt;
      if (gnt) begin
        a <= bus.req_din0[gnt_id*DIN0_WIDTH +: DIN0_WIDTH];
        b <= bus.req_din1[gnt_id*DIN1_WIDTH +: DIN1_WIDTH];
        s1_id <= gnt_id;
        ptr <= (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      if (s2_adv) begin
        bus.rsp_valid <= s1_v;
        if (s1_v) begin
          bus.rsp_dout <= bus.mul_dout;
          bus.rsp_id <= s1_id;
        end
      end
    end
  end
endmodule

// File: tb/tb_decoder_mul_rr_arbiter.sv
// tb_decoder_mul_rr_arbiter: directed scenario tasks with hand-computed expectations
module tb_decoder_mul_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  int errs = 0;
  int chks = 0;
  decoder_mul_rr_arbiter_if bus ();
  decoder_mul_rr_arbiter dut (.ap_clk(clk), .ap_rst(rst), .bus(bus));
  assign bus.mul_dout = bus.mul_din0 * bus.mul_din1;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ops(input logic signed [15:0] d0 [4], input logic signed [9:0] d1 [4]);
    bus.req_din0 = {d0[3], d0[2], d0[1], d0[0]};
    bus.req_din1 = {d1[3], d1[2], d1[1], d1[0]};
  endtask
  task automatic do_reset();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    #1;
    chks++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL reset_ready_during got=%b want=0000", bus.req_ready); end
    tick();
    tick();
    bus.req_valid = '0;
    rst = 1'b0;
    #1;
    chks++; if (bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
    chks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    chks++; if (bus.rsp_dout !== 26'sd0) begin errs++; $display("FAIL reset_dout got=%0d want=0", bus.rsp_dout); end
    chks++; if (bus.rsp_id !== 2'd0) begin errs++; $display("FAIL reset_id got=%0d want=0", bus.rsp_id); end
    chks++; if (bus.mul_din0 !== 16'sd0 || bus.mul_din1 !== 10'sd0) begin errs++; $display("FAIL reset_mul_din got=%0d,%0d want=0,0", bus.mul_din0, bus.mul_din1); end
  endtask
  task automatic test_single();
    logic signed [15:0] d0 [4] = '{0, 0, 1000, 0};
    logic signed [9:0] d1 [4] = '{0, 0, -3, 0};
    do_reset();
    set_ops(d0, d1);
    bus.req_valid = 4'b0100;
    #1;
    chks++; if (bus.req_ready !== 4'b0100) begin errs++; $display("FAIL single_ready got=%b want=0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    chks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin errs++; $display("FAIL single_t1 got=v%b b%b want=v0 b1", bus.rsp_valid, bus.busy); end
    chks++; if (bus.mul_din0 !== 16'sd1000 || bus.mul_din1 !== -10'sd3) begin errs++; $display("FAIL single_mul_din got=%0d,%0d want=1000,-3", bus.mul_din0, bus.mul_din1); end
    tick();
    chks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dout !== -26'sd3000 || bus.rsp_id !== 2'd2) begin errs++; $display("FAIL single_rsp got=v%b %0d id%0d want=v1 -3000 id2", bus.rsp_valid, bus.rsp_dout, bus.rsp_id); end
    tick();
    chks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errs++; $display("FAIL single_idle got=b%b v%b want=b0 v0", bus.busy, bus.rsp_valid); end
  endtask
  task automatic test_round_robin();
    logic signed [15:0] d0 [4] = '{100, -200, 300, -400};
    logic signed [9:0] d1 [4] = '{5, 6, -7, 8};
    logic signed [25:0] prod [4] = '{500, -1200, -2100, -3200};
    logic [3:0] er;
    do_reset();
    set_ops(d0, d1);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      er = 4'b0001 << (c % 4);
      chks++; if (bus.req_ready !== er) begin errs++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, bus.req_ready, er); end
      if (c >= 2) begin
        chks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'((c - 2) % 4) || bus.rsp_dout !== prod[(c - 2) % 4]) begin errs++; $display("FAIL rr_rsp c=%0d got=v%b id%0d %0d want=v1 id%0d %0d", c, bus.rsp_valid, bus.rsp_id, bus.rsp_dout, (c - 2) % 4, prod[(c - 2) % 4]); end
      end
      tick();
    end
    bus.req_valid = '0;
    tick();
    tick();
  endtask
  task automatic test_extremes();
    logic signed [15:0] d0 [4] = '{-32768, 32767, 0, 0};
    logic signed [9:0] d1 [4] = '{-512, -512, 0, 0};
    do_reset();
    set_ops(d0, d1);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0010;
    #1;
    chks++; if (bus.req_ready !== 4'b0010) begin errs++; $display("FAIL ext_ready got=%b want=0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    chks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dout !== 26'sd16777216 || bus.rsp_id !== 2'd0) begin errs++; $display("FAIL ext_min_min got=%0d id%0d want=16777216 id0", bus.rsp_dout, bus.rsp_id); end
    tick();
    chks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dout !== -26'sd16776704 || bus.rsp_id !== 2'd1) begin errs++; $display("FAIL ext_max_min got=%0d id%0d want=-16776704 id1", bus.rsp_dout, bus.rsp_id); end
    tick();
  endtask
  task automatic test_backpressure();
    logic signed [15:0] d0 [4] = '{0, 0, 0, 0};
    logic signed [9:0] d1 [4] = '{0, 3, 0, 0};
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      d0[1] = 16'(10 + c);
      set_ops(d0, d1);
      bus.req_valid = (c <= 8) ? 4'b0010 : 4'b0000;
      bus.rsp_ready = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
      #1;
      if (c <= 2 || c == 8) begin
        chks++; if (bus.req_ready !== 4'b0010) begin errs++; $display("FAIL bp_grant c=%0d got=%b want=0010", c, bus.req_ready); end
      end
      if (c == 2) begin
        chks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dout !== 26'sd30) begin errs++; $display("FAIL bp_first c=%0d got=%0d want=30", c, bus.rsp_dout); end
      end
      if (c >= 3 && c <= 8) begin
        chks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dout !== 26'sd33 || bus.rsp_id !== 2'd1 || bus.busy !== 1'b1) begin errs++; $display("FAIL bp_hold c=%0d got=v%b %0d id%0d want=v1 33 id1", c, bus.rsp_valid, bus.rsp_dout, bus.rsp_id); end
      end
      if (c >= 3 && c <= 7) begin
        chks++; if (bus.req_ready !== 4'b0000 || bus.mul_din0 !== 16'sd12) begin errs++; $display("FAIL bp_stall c=%0d got=%b s1=%0d want=0000 s1=12", c, bus.req_ready, bus.mul_din0); end
      end
      if (c == 9) begin
        chks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dout !== 26'sd36) begin errs++; $display("FAIL bp_drain1 got=%0d want=36", bus.rsp_dout); end
      end
      if (c == 10) begin
        chks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dout !== 26'sd54) begin errs++; $display("FAIL bp_drain2 got=%0d want=54", bus.rsp_dout); end
      end
      tick();
    end
    chks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL bp_empty got=%b want=0", bus.busy); end
  endtask
  task automatic test_fairness();
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b1001;
    #1;
    chks++; if (bus.req_ready !== 4'b1000) begin errs++; $display("FAIL fair_first got=%b want=1000", bus.req_ready); end
    tick();
    chks++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL fair_second got=%b want=0001", bus.req_ready); end
    tick();
    chks++; if (bus.req_ready !== 4'b1000) begin errs++; $display("FAIL fair_third got=%b want=1000", bus.req_ready); end
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tick();
  endtask
  task automatic test_reset_midstream();
    logic signed [15:0] d0 [4] = '{11, 0, -7, 0};
    logic signed [9:0] d1 [4] = '{13, 0, 9, 0};
    do_reset();
    set_ops(d0, d1);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    tick();
    tick();
    chks++; if (bus.rsp_valid !== 1'b1 || bus.mul_din0 !== 16'sd11) begin errs++; $display("FAIL mid_full got=v%b s1=%0d want=v1 s1=11", bus.rsp_valid, bus.mul_din0); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    chks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.mul_din0 !== 16'sd0) begin errs++; $display("FAIL mid_cleared got=v%b b%b m%0d want=v0 b0 m0", bus.rsp_valid, bus.busy, bus.mul_din0); end
    chks++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL mid_ptr got=%b want=0001", bus.req_ready); end
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    chks++; if (bus.req_ready !== 4'b0100) begin errs++; $display("FAIL mid_grant got=%b want=0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    chks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_dout !== -26'sd63 || bus.rsp_id !== 2'd2) begin errs++; $display("FAIL mid_rsp got=v%b %0d id%0d want=v1 -63 id2", bus.rsp_valid, bus.rsp_dout, bus.rsp_id); end
  endtask
  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_din0 = '0;
    bus.req_din1 = '0;
    bus.rsp_ready = 1'b1;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_extremes();
    test_backpressure();
    test_fairness();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
